// File: rtl/s2mm_capture_ctrl.sv
// Capture controller: decimates a non-stallable source stream, frames it into
// packets of pkt_len beats and hands it to a DMA S2MM channel.
// Optional drop counter is built when S2MM_CAPTURE_DROP_CNT_EN is defined.
`timescale 1ns/1ps

module s2mm_capture_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 26
) (
  input  logic               axis_aclk,
  input  logic               axis_areset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   decim,
  input  logic [15:0]        pkt_len,
  input  logic [15:0]        pkt_num,
  input  logic               s_axis_tvalid,
  input  logic [WIDTH-1:0]   s_axis_tdata,
  input  logic [WIDTH/8-1:0] s_axis_tkeep,
  output logic               s_axis_tready,
  output logic               m_axis_tvalid,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic [WIDTH/8-1:0] m_axis_tkeep,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP_PEND,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     decim_q, decim_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          num_q, num_d;
  logic [CNT_W-1:0]     phase_q, phase_d;
  logic [15:0]          beat_q, beat_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;
  logic                 rdy_q;
  logic                 m_valid_q, m_valid_d;
  logic [WIDTH-1:0]     m_data_q, m_data_d;
  logic [WIDTH/8-1:0]   m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;

  logic                 capturing;
  logic                 in_beat;
  logic                 keep_beat;
  logic                 can_load;
  logic                 load;
  logic                 last_beat;
  logic                 hs_last;
  logic [15:0]          pkts_done;
  logic                 final_pkt;
  logic                 arm;

  assign capturing = (state_q == ST_RUN) || (state_q == ST_STOP_PEND);
  assign in_beat   = capturing && s_axis_tvalid;
  assign keep_beat = in_beat && (phase_q == '0);
  assign can_load  = !m_valid_q || m_axis_tready;
  assign load      = keep_beat && can_load;
  assign last_beat = (beat_q == len_q - 16'd1) || (state_q == ST_STOP_PEND);
  assign hs_last   = m_valid_q && m_axis_tready && m_last_q;
  assign arm       = (state_q == ST_IDLE) && start;

  // A load implies the previous beat is gone or leaving this cycle, so counting
  // its tlast handshake now keeps the packet-limit check exact for pkt_len=1.
  assign pkts_done = pkt_cnt_q + {15'd0, hs_last};
  assign final_pkt = (num_q != 16'd0) && ((pkts_done + 16'd1) == num_q);

  // NOTE: every variable assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    decim_d   = decim_q;
    len_d     = len_q;
    num_d     = num_q;
    phase_d   = phase_q;
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;

    if (in_beat) begin
      phase_d = (phase_q == decim_q) ? '0 : phase_q + CNT_W'(1);
    end

    if (hs_last) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = s_axis_tdata;
      m_keep_d  = s_axis_tkeep;
      m_last_d  = last_beat;
      beat_d    = last_beat ? 16'd0 : beat_q + 16'd1;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          decim_d   = decim;
          len_d     = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
          num_d     = pkt_num;
          phase_d   = '0;
          beat_d    = 16'd0;
          pkt_cnt_d = 16'd0;
        end
      end
      ST_RUN: begin
        if (load && last_beat && final_pkt) begin
          state_d = ST_DONE;
        end else if (stop) begin
          // Judge the packet boundary after this cycle's load, so a beat
          // loaded alongside stop is never left in an unterminated packet.
          state_d = (beat_d == 16'd0) ? ST_DONE : ST_STOP_PEND;
        end
      end
      ST_STOP_PEND: begin
        if (load) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!m_valid_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q   <= ST_IDLE;
      decim_q   <= '0;
      len_q     <= 16'd0;
      num_q     <= 16'd0;
      phase_q   <= '0;
      beat_q    <= 16'd0;
      pkt_cnt_q <= 16'd0;
      rdy_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      decim_q   <= decim_d;
      len_q     <= len_d;
      num_q     <= num_d;
      phase_q   <= phase_d;
      beat_q    <= beat_d;
      pkt_cnt_q <= pkt_cnt_d;
      rdy_q     <= 1'b1;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

`ifdef S2MM_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_q;
  logic        drop_beat;

  assign drop_beat = keep_beat && !can_load;

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      drop_q <= 16'd0;
    end else if (arm) begin
      drop_q <= 16'd0;
    end else if (drop_beat && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  logic unused_arm;
  assign unused_arm = arm;
  assign drop_cnt   = 16'd0;
`endif

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE) && !m_valid_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_s2mm_capture_ctrl.sv
// Directed bench for s2mm_capture_ctrl: framing, decimation, stop handling,
// backpressure drops and mid-capture reset, with hand-computed expectations.
`timescale 1ns/1ps

module tb_s2mm_capture_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 26;

  logic               clk = 1'b0;
  logic               areset;
  logic               start, stop;
  logic [CNT_W-1:0]   decim;
  logic [15:0]        pkt_len, pkt_num;
  logic               s_tvalid;
  logic [WIDTH-1:0]   s_tdata;
  logic [WIDTH/8-1:0] s_tkeep;
  logic               s_tready;
  logic               m_tvalid;
  logic [WIDTH-1:0]   m_tdata;
  logic [WIDTH/8-1:0] m_tkeep;
  logic               m_tlast;
  logic               m_tready;
  logic               busy, done;
  logic [15:0]        pkt_cnt, drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [WIDTH-1:0] got_data[$];
  bit               got_last[$];

`ifdef S2MM_CAPTURE_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd3;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  always #5 clk = ~clk;

  s2mm_capture_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .axis_aclk     (clk),
    .axis_areset   (areset),
    .start         (start),
    .stop          (stop),
    .decim         (decim),
    .pkt_len       (pkt_len),
    .pkt_num       (pkt_num),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .busy          (busy),
    .done          (done),
    .pkt_cnt       (pkt_cnt),
    .drop_cnt      (drop_cnt)
  );

  // Inputs change 1 ns after posedge, so at negedge they hold their values
  // for the coming edge and a valid&&ready here is a real handshake.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      got_data.push_back(m_tdata);
      got_last.push_back(m_tlast);
    end
    if (done) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_data.delete();
    got_last.delete();
    done_cnt = 0;
  endtask

  task automatic arm(input logic [CNT_W-1:0] d, input logic [15:0] len,
                     input logic [15:0] num, input logic with_stop);
    decim   = d;
    pkt_len = len;
    pkt_num = num;
    start   = 1'b1;
    stop    = with_stop;
    cycle();
    start   = 1'b0;
    stop    = 1'b0;
  endtask

  task automatic stream(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = WIDTH'(first + i);
      cycle();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) break;
      cycle();
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_beat(input string tag, input int idx,
                            input logic [31:0] exp_d, input bit exp_l);
    logic [31:0] d;
    logic [31:0] l;
    d = (idx < got_data.size()) ? got_data[idx] : 32'hDEAD_BEEF;
    l = (idx < got_last.size()) ? {31'd0, got_last[idx]} : 32'hDEAD_BEEF;
    check($sformatf("%s_data%0d", tag, idx), d, exp_d);
    check($sformatf("%s_last%0d", tag, idx), l, {31'd0, exp_l});
  endtask

  int exp4[4] = '{0, 4, 5, 6};

  initial begin
    areset   = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    decim    = '0;
    pkt_len  = 16'd0;
    pkt_num  = 16'd0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '1;
    m_tready = 1'b1;

    // Reset state
    cycle(); cycle(); cycle();
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tlast",  {31'd0, m_tlast},  32'd0);
    check("rst_tdata",  m_tdata, 32'd0);
    check("rst_busy",   {31'd0, busy},     32'd0);
    check("rst_done",   {31'd0, done},     32'd0);
    check("rst_pktcnt", {16'd0, pkt_cnt},  32'd0);
    check("rst_dropcnt", {16'd0, drop_cnt}, 32'd0);
    check("rst_sready", {31'd0, s_tready}, 32'd0);
    areset = 1'b0;
    cycle();
    check("sready_up", {31'd0, s_tready}, 32'd1);

    // decim=0, pkt_len=4, pkt_num=2, input 0..9 -> 0..7, tlast on 3 and 7
    clear_log();
    arm(26'd0, 16'd4, 16'd2, 1'b0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    stream(0, 10);
    wait_idle("t1", 20);
    check("t1_nbeats", got_data.size(), 32'd8);
    for (int i = 0; i < 8; i++) check_beat("t1", i, 32'(i), (i % 4) == 3);
    check("t1_done", done_cnt, 32'd1);
    check("t1_pktcnt", {16'd0, pkt_cnt}, 32'd2);

    // decim=2, pkt_len=3, pkt_num=1, input 0..11 -> 0,3,6 with tlast on 6
    clear_log();
    arm(26'd2, 16'd3, 16'd1, 1'b0);
    stream(0, 12);
    wait_idle("t2", 20);
    check("t2_nbeats", got_data.size(), 32'd3);
    for (int i = 0; i < 3; i++) check_beat("t2", i, 32'(3 * i), i == 2);
    check("t2_done", done_cnt, 32'd1);
    check("t2_pktcnt", {16'd0, pkt_cnt}, 32'd1);

    // Continuous capture, stop after 5 loaded beats -> 6th beat closes packet
    clear_log();
    arm(26'd0, 16'd8, 16'd0, 1'b0);
    stream(0, 5);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("t3_pend_busy", {31'd0, busy}, 32'd1);
    cycle(); cycle();
    check("t3_pend_still", {31'd0, busy}, 32'd1);
    check("t3_pend_done", done_cnt, 32'd0);
    stream(5, 2);
    wait_idle("t3", 20);
    check("t3_nbeats", got_data.size(), 32'd6);
    for (int i = 0; i < 6; i++) check_beat("t3", i, 32'(i), i == 5);
    check("t3_done", done_cnt, 32'd1);
    check("t3_pktcnt", {16'd0, pkt_cnt}, 32'd1);

    // Backpressure for 3 cycles: held output, 3 kept beats dropped
    clear_log();
    arm(26'd0, 16'd4, 16'd1, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd0;
    cycle();
    m_tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_tdata = 32'(i);
      cycle();
      check($sformatf("t4_hold_valid%0d", i), {31'd0, m_tvalid}, 32'd1);
      check($sformatf("t4_hold_data%0d", i), m_tdata, 32'd0);
    end
    check("t4_hold_keep", {28'd0, m_tkeep}, 32'hF);
    m_tready = 1'b1;
    stream(4, 4);
    wait_idle("t4", 20);
    check("t4_nbeats", got_data.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_beat("t4", i, 32'(exp4[i]), i == 3);
    check("t4_dropcnt", {16'd0, drop_cnt}, {16'd0, EXP_DROPS});
    check("t4_done", done_cnt, 32'd1);

    // Reset mid-packet abandons the pending beat
    clear_log();
    arm(26'd0, 16'd4, 16'd0, 1'b0);
    stream(0, 6);
    check("t5_pre_pktcnt", {16'd0, pkt_cnt}, 32'd1);
    check("t5_pre_valid", {31'd0, m_tvalid}, 32'd1);
    m_tready = 1'b0;
    areset   = 1'b1;
    cycle();
    check("t5_rst_valid",  {31'd0, m_tvalid}, 32'd0);
    check("t5_rst_last",   {31'd0, m_tlast},  32'd0);
    check("t5_rst_busy",   {31'd0, busy},     32'd0);
    check("t5_rst_pktcnt", {16'd0, pkt_cnt},  32'd0);
    check("t5_rst_sready", {31'd0, s_tready}, 32'd0);
    areset   = 1'b0;
    m_tready = 1'b1;
    cycle();
    check("t5_sready", {31'd0, s_tready}, 32'd1);

    // start and stop together in IDLE: start wins, capture runs normally
    clear_log();
    arm(26'd0, 16'd4, 16'd1, 1'b1);
    check("t6_busy", {31'd0, busy}, 32'd1);
    stream(10, 5);
    wait_idle("t6", 20);
    check("t6_nbeats", got_data.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_beat("t6", i, 32'(10 + i), i == 3);
    check("t6_done", done_cnt, 32'd1);
    check("t6_pktcnt", {16'd0, pkt_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s2mm_capture_ctrl.md
S2MM_CAPTURE_CTRL -- requirements
Module: s2mm_capture_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, stream data width; CNT_W, default 26, decimation counter width.
REQ-002 Clocking and reset SHALL be one clock and one synchronous, active-high reset.
REQ-003 axis_aclk  in  1  sole clock.
REQ-004 axis_areset  in  1  synchronous active-high reset.
REQ-005 start  in  1  one-cycle pulse that arms a capture.
REQ-006 stop  in  1  one-cycle pulse that ends the capture at the next packet boundary.
REQ-007 decim  in  CNT_W  keep 1 of every decim+1 input beats; 0 = keep all.
REQ-008 pkt_len  in  16  beats per packet; 0 treated as 1.
REQ-009 pkt_num  in  16  packets per capture; 0 = continuous until stop.
REQ-010 s_axis_tvalid/tdata/tkeep  in  1/WIDTH/WIDTH/8  source stream (no tlast; source cannot stall).
REQ-011 s_axis_tready  out  1  constant 1 once out of reset.
REQ-012 m_axis_tvalid/tdata/tkeep/tlast  out  1/WIDTH/WIDTH/8/1  framed stream to DMA S2MM.
REQ-013 m_axis_tready  in  1  DMA backpressure.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on capture completion.
REQ-016 pkt_cnt  out  16  packets completed (tlast handshakes) in the current/last capture.
REQ-017 drop_cnt  out  16  dropped kept beats, saturating (see Configuration).

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, STOP_PEND and DONE.
REQ-019 IDLE: input beats SHALL be consumed and discarded; on start, decim/pkt_len/pkt_num SHALL be latched, the phase, beat, pkt_cnt and drop_cnt counters SHALL be cleared, and the FSM SHALL go to RUN the next cycle.
REQ-020 An input beat SHALL be "kept" when the FSM is in RUN or STOP_PEND, s_axis_tvalid=1 and phase==0; phase SHALL increment on every valid input beat in those states and wrap from latched decim to 0.
REQ-021 A kept beat SHALL load the single output register when m_axis_tvalid==0 or m_axis_tready==1 (same-cycle replace allowed); latency input to m_axis_tvalid SHALL be 1 cycle.
REQ-022 A kept beat arriving when m_axis_tvalid==1 and m_axis_tready==0 SHALL be dropped: the output SHALL be unchanged, beat count SHALL NOT advance, phase SHALL still advance, and drop_cnt SHALL increment.
REQ-023 m_axis_tlast SHALL be 1 on the loaded beat whose beat index equals pkt_len-1, or on the first loaded beat in STOP_PEND; the beat counter SHALL reset to 0 after a tlast beat is loaded.
REQ-024 pkt_cnt SHALL increment on each m_axis handshake with tlast=1.
REQ-025 RUN -> DONE SHALL occur when a tlast beat is loaded and, with pkt_num!=0, pkt_cnt+1 equals pkt_num.
REQ-026 On stop in RUN: with beat counter==0 the FSM SHALL go to DONE; otherwise it SHALL go to STOP_PEND and close the packet with the next loaded beat, then go to DONE.
REQ-027 DONE SHALL discard input, wait until m_axis_tvalid==0, pulse done for one cycle, and return to IDLE.
REQ-028 start SHALL be ignored when busy; stop SHALL be ignored in IDLE, STOP_PEND and DONE; when start and stop arrive together in IDLE, start SHALL take effect and stop SHALL be ignored.
REQ-029 m_axis_tdata/tkeep SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.

Reset
REQ-030 On axis_areset the block SHALL set the state to IDLE, m_axis_tvalid/tlast=0, m_axis_tdata/tkeep=0, busy=0, done=0, pkt_cnt=0, drop_cnt=0 and all internal counters to 0, and s_axis_tready SHALL be 0 during reset.
REQ-031 A reset mid-capture SHALL abandon any pending output beat without emitting tlast.

Configuration
REQ-032 With macro S2MM_CAPTURE_DROP_CNT_EN defined, drop_cnt SHALL count per REQ-022 and saturate at 0xFFFF; without it, drop_cnt SHALL be tied to 0, its counter logic SHALL be absent, and dropping behaviour SHALL otherwise be identical.

Verification
REQ-033 decim=0, pkt_len=4, pkt_num=2, m_axis_tready=1, continuous input 0..9 -> output 0..7, tlast on 3 and 7, done pulses once, pkt_cnt=2.
REQ-034 decim=2, pkt_len=3, pkt_num=1, input 0..11 -> output 0,3,6 with tlast on 6, then done.
REQ-035 pkt_num=0, pkt_len=8, stop after 5 loaded beats -> STOP_PEND, 6th beat carries tlast, done, pkt_cnt=1.
REQ-036 m_axis_tready=0 for 3 cycles with continuous input, decim=0 -> output beat held, 3 beats dropped, drop_cnt=3 (0 without the macro), beat indices skip no tlast position.
REQ-037 axis_areset asserted mid-packet -> next cycle m_axis_tvalid=0, busy=0, pkt_cnt=0; start and stop asserted together in IDLE -> capture begins.
